truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Upstream stimulus and scoring stage for an evolved N-input combinational candidate circuit (4-input, 1-output in the default configuration).
- Drives every input vector 0..2^N_IN-1 into the candidate and waits a settle interval. It then samples the candidate output, assembles the observed truth table and counts matches against a target truth table.
- Presents the result (observed table plus fitness) to the GP selection logic over a valid/ready handshake.

Parameters:
- N_IN, 4, number of candidate inputs; vector count is 2^N_IN.
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- target_tt  input  2^N_IN  target truth table; bit i is the required output for vector i. Latched on accepted start.
- vec_out  output  N_IN  vector driven to the candidate. MSB is the first candidate input (a), LSB is the last (d).
- dut_in  input  1  candidate output (e), sampled in SAMPLE.
- busy  output  1  high from accepted start until result accepted.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts result.
- observed_tt  output  2^N_IN  captured candidate truth table; bit i = dut_in sampled for vector i.
- fitness  output  N_IN+1  number of vectors where dut_in == target bit; range 0..2^N_IN.

Behaviour:
- Reset values: vec_out=0, busy=0, result_valid=0, observed_tt=0, fitness=0, state=IDLE, internal counters=0. Reset mid-sweep or mid-REPORT aborts immediately, with no partial result presented.
- IDLE:
  - start=1 latches target_tt, clears observed_tt, fitness and vec_out to 0, sets busy=1, and moves to DRIVE.
  - start=0 holds all outputs.
- DRIVE:
  - vec_out is stable for SETTLE cycles (settle counter 0..SETTLE-1), then moves to SAMPLE.
- SAMPLE (one cycle):
  - observed_tt[vec_out] <= dut_in.
  - fitness increments by 1 when dut_in == latched_target[vec_out].
  - If vec_out == 2^N_IN-1, go to REPORT with vec_out left at its final value.
  - Otherwise vec_out wraps-safe increments and the state returns to DRIVE.
- REPORT:
  - result_valid=1 with observed_tt/fitness stable.
  - result_valid && result_ready moves to IDLE in the same edge: result_valid=0, busy=0.
  - result_ready may be held low indefinitely; outputs must not change while held.
- Latency:
  - Each vector costs SETTLE+1 cycles.
  - result_valid rises 2^N_IN*(SETTLE+1) cycles after the start edge; 32 cycles at defaults.
- start while not IDLE: ignored, with no effect on the sweep or the latched target. start and result_ready coincident in REPORT: the transition is to IDLE only; a new start is needed the next cycle.
- Width rules:
  - fitness is N_IN+1 bits so 2^N_IN is representable without overflow.
  - The vector counter is N_IN bits; the terminal test is on equality with all-ones, never on wrap.
- observed_tt and fitness are registered outputs. dut_in is assumed combinationally dependent on vec_out only.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_DONTCARE_EN.
- When defined:
  - Adds input care_mask (2^N_IN), latched on start alongside target_tt.
  - Vectors with care_mask[i]=0 always count as a match; observed_tt still records the sampled value.
- When undefined: no port, and every vector is scored against target_tt.

Decomposition:
- Package truth_table_sweeper_pkg holds:
  - state enum {IDLE, DRIVE, SAMPLE, REPORT};
  - localparam/function for NUM_VEC = 2^N_IN;
  - fitness width N_IN+1;
  - settle counter width of 4 bits.
- One natural sub-module, tts_settle_timer: a loadable down-counter producing a one-cycle expiry pulse after SETTLE cycles. The FSM, vector counter and scoring stay in the top.

Test Plan:
- Bench candidate e=1 only for vectors 13,14; target_tt=16'h6000; start -> after 32 cycles result_valid=1, observed_tt=16'h6000, fitness=16.
- Constant-0 candidate, target_tt=16'h6000 -> observed_tt=16'h0000, fitness=14; constant-1 candidate -> observed_tt=16'hFFFF, fitness=2.
- Hold result_ready=0 for 10 cycles after result_valid -> outputs frozen and busy=1; assert result_ready -> next cycle result_valid=0, busy=0.
- Assert start during DRIVE of vector 5 with a different target_tt -> ignored; final fitness matches the original target.
- Assert rst at vector 9 -> next cycle all outputs 0, IDLE. A fresh start then completes a clean 32-cycle sweep.
- SETTLE=3 -> result_valid at cycle 64; with DONTCARE_EN, care_mask=16'h00FF, constant-0 candidate, target_tt=16'h6000 -> fitness=16.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared state encoding and sizing helpers for the truth-table sweeper
package truth_table_sweeper_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, REPORT} state_t;
  localparam int SETTLE_W = 4;
  function automatic int num_vec(input int n);
    return 1 << n;
  endfunction
  function automatic int fit_w(input int n);
    return n + 1;
  endfunction
endpackage

// File: rtl/tts_settle_timer.sv
// tts_settle_timer: loadable down-counter, expire is high in the last enabled cycle of the settle window
module tts_settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= load ? load_val : (en && cnt != '0) ? cnt - 1'b1 : cnt;
  always_comb expire = en && cnt == '0;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all input vectors into a candidate and scores it; TRUTH_TABLE_SWEEPER_DONTCARE_EN adds care_mask
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SETTLE = 1,
  localparam int NV = num_vec(N_IN),
  localparam int FW = fit_w(N_IN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NV-1:0] target_tt,
`ifdef TRUTH_TABLE_SWEEPER_DONTCARE_EN
  input  logic [NV-1:0] care_mask,
`endif
  output logic [N_IN-1:0] vec_out,
  input  logic          dut_in,
  output logic          busy,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [NV-1:0] observed_tt,
  output logic [FW-1:0] fitness
);
  state_t state, state_nx;
  logic [NV-1:0] target_q;
  logic expire, load, last, match;
  always_comb last = vec_out == '1;
  always_comb load = (state == IDLE && start) || (state == SAMPLE && !last);
`ifdef TRUTH_TABLE_SWEEPER_DONTCARE_EN
  logic [NV-1:0] care_q;
  always_comb match = !care_q[vec_out] || dut_in == target_q[vec_out];
`else
  always_comb match = dut_in == target_q[vec_out];
`endif
  tts_settle_timer #(.W(SETTLE_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .en(state == DRIVE),
    .load_val(SETTLE_W'(SETTLE - 1)),
    .expire(expire)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    case (state)
      IDLE:    state_nx = start ? DRIVE : IDLE;
      DRIVE:   state_nx = expire ? SAMPLE : DRIVE;
      SAMPLE:  state_nx = last ? REPORT : DRIVE;
      default: state_nx = result_ready ? IDLE : REPORT;
    endcase
  always_comb begin
    busy = state != IDLE;
    result_valid = state == REPORT;
  end
  always_ff @(posedge clk)
    if (rst) begin
      vec_out <= '0;
      observed_tt <= '0;
      fitness <= '0;
      target_q <= '0;
`ifdef TRUTH_TABLE_SWEEPER_DONTCARE_EN
      care_q <= '0;
`endif
    end else if (state == IDLE && start) begin
      vec_out <= '0;
      observed_tt <= '0;
      fitness <= '0;
      target_q <= target_tt;
`ifdef TRUTH_TABLE_SWEEPER_DONTCARE_EN
      care_q <= care_mask;
`endif
    end else if (state == SAMPLE) begin
      observed_tt[vec_out] <= dut_in;
      fitness <= fitness + FW'(match);
      vec_out <= last ? vec_out : vec_out + 1'b1;
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of sweep results, handshake, abort and SETTLE=3 latency
module tb_truth_table_sweeper;
  logic clk = 0, rst = 1, start = 0, result_ready = 0, dut_in;
  logic [15:0] target_tt = 16'h6000, care_mask = 16'hFFFF;
  logic [3:0] vec_out;
  logic busy, result_valid;
  logic [15:0] observed_tt;
  logic [4:0] fitness;
  logic start2 = 0, ready2 = 0, busy2, rv2;
  logic [15:0] care2 = 16'h00FF, obs2;
  logic [3:0] vec2;
  logic [4:0] fit2;
  int checks = 0, failures = 0, mode = 0, n = 0;

  always #5 clk = ~clk;
  always_comb dut_in = mode == 0 ? (vec_out == 4'd13 || vec_out == 4'd14) : mode == 2;

  truth_table_sweeper u1 (
    .clk(clk), .rst(rst), .start(start), .target_tt(target_tt),
`ifdef TRUTH_TABLE_SWEEPER_DONTCARE_EN
    .care_mask(care_mask),
`endif
    .vec_out(vec_out), .dut_in(dut_in), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .observed_tt(observed_tt), .fitness(fitness)
  );

  truth_table_sweeper #(.SETTLE(3)) u2 (
    .clk(clk), .rst(rst), .start(start2), .target_tt(target_tt),
`ifdef TRUTH_TABLE_SWEEPER_DONTCARE_EN
    .care_mask(care2),
`endif
    .vec_out(vec2), .dut_in(1'b0), .busy(busy2), .result_valid(rv2),
    .result_ready(ready2), .observed_tt(obs2), .fitness(fit2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rv(output int cnt);
    cnt = 0;
    while (!result_valid && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  task automatic sweep(output int cnt);
    start = 1;
    tick();
    start = 0;
    wait_rv(cnt);
  endtask

  task automatic accept();
    result_ready = 1;
    tick();
    result_ready = 0;
  endtask

  task automatic wait_vec(input logic [3:0] v);
    int k = 0;
    while (vec_out != v && k < 100) begin
      tick();
      k++;
    end
    check("reach_vec", vec_out, v);
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    check("rst_vec", vec_out, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_obs", observed_tt, 0);
    check("rst_fit", fitness, 0);

    mode = 0;
    sweep(n);
    check("t1_latency", n, 32);
    check("t1_obs", observed_tt, 16'h6000);
    check("t1_fit", fitness, 16);
    check("t1_busy", busy, 1);
    repeat (10) tick();
    check("hold_valid", result_valid, 1);
    check("hold_busy", busy, 1);
    check("hold_obs", observed_tt, 16'h6000);
    check("hold_fit", fitness, 16);
    check("hold_vec", vec_out, 4'hF);
    accept();
    check("acc_valid", result_valid, 0);
    check("acc_busy", busy, 0);
    check("idle_obs_hold", observed_tt, 16'h6000);

    mode = 1;
    sweep(n);
    check("c0_obs", observed_tt, 16'h0000);
    check("c0_fit", fitness, 14);
    accept();

    mode = 2;
    sweep(n);
    check("c1_obs", observed_tt, 16'hFFFF);
    check("c1_fit", fitness, 2);
    start = 1;
    result_ready = 1;
    tick();
    start = 0;
    result_ready = 0;
    check("coinc_busy", busy, 0);
    check("coinc_valid", result_valid, 0);
    tick();
    check("coinc_stay_idle", busy, 0);

    mode = 0;
    start = 1;
    tick();
    start = 0;
    wait_vec(4'd5);
    target_tt = 16'h0000;
    start = 1;
    tick();
    start = 0;
    target_tt = 16'h6000;
    wait_rv(n);
    check("ign_valid", result_valid, 1);
    check("ign_fit", fitness, 16);
    check("ign_obs", observed_tt, 16'h6000);
    accept();

    mode = 1;
    start = 1;
    tick();
    start = 0;
    wait_vec(4'd9);
    rst = 1;
    tick();
    rst = 0;
    check("abort_vec", vec_out, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_obs", observed_tt, 0);
    check("abort_fit", fitness, 0);
    tick();
    check("abort_idle", busy, 0);
    mode = 0;
    sweep(n);
    check("fresh_latency", n, 32);
    check("fresh_fit", fitness, 16);
    check("fresh_obs", observed_tt, 16'h6000);
    accept();

    start2 = 1;
    tick();
    start2 = 0;
    n = 0;
    while (!rv2 && n < 300) begin
      tick();
      n++;
    end
    check("s3_latency", n, 64);
    check("s3_obs", obs2, 16'h0000);
`ifdef TRUTH_TABLE_SWEEPER_DONTCARE_EN
    check("s3_fit", fit2, 16);
`else
    check("s3_fit", fit2, 14);
`endif
    ready2 = 1;
    tick();
    ready2 = 0;
    check("s3_acc", rv2, 0);
    check("s3_busy", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
